// File: rtl/currctrl_dpram.sv
// Dual-port word RAM with per-byte write lanes, a write-freeze input and an
// optional zero-fill sequence after reset that holds both ports in waitrequest.
module currctrl_dpram #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic                  a_chipselect,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_W/8-1:0]   a_byteenable,
  input  logic [DATA_W-1:0]     a_writedata,
  input  logic [ADDR_W-1:0]     b_address,
  input  logic                  b_chipselect,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_W/8-1:0]   b_byteenable,
  input  logic [DATA_W-1:0]     b_writedata,
  input  logic                  freeze,
  output logic [DATA_W-1:0]     a_readdata,
  output logic                  a_readdatavalid,
  output logic                  a_waitrequest,
  output logic [DATA_W-1:0]     b_readdata,
  output logic                  b_readdatavalid,
  output logic                  b_waitrequest,
  output logic                  init_done
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {RST, CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready_p0, clr_vld_p0;
  logic                a_wr_p0, b_wr_p0, a_vld_p0, b_vld_p0, same_wr_p0;
  logic [DATA_W-1:0]   a_word_p0, b_word_p0, a_base_p0;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] w;
    w = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
    end
    return w;
  endfunction

  // Stage p0: transfer acceptance, same-cycle forwarding and write merging
  assign ready_p0   = reset_n && (state == READY);
  assign clr_vld_p0 = reset_n && (state == CLEAR);
  assign a_wr_p0    = ready_p0 && !a_waitrequest && a_chipselect && a_write && !freeze;
  assign b_wr_p0    = ready_p0 && !b_waitrequest && b_chipselect && b_write && !freeze;
  assign a_vld_p0   = ready_p0 && !a_waitrequest && a_chipselect && a_read && !a_write;
  assign b_vld_p0   = ready_p0 && !b_waitrequest && b_chipselect && b_read && !b_write;
  assign same_wr_p0 = a_wr_p0 && b_wr_p0 && (a_address == b_address);

  always_comb begin
    a_word_p0 = mem[a_address];
    b_word_p0 = mem[b_address];
    a_base_p0 = mem[a_address];
    // A reader sees the other port's write lanes merged over the stored word
    if (b_wr_p0 && (b_address == a_address)) a_word_p0 = byte_merge(a_word_p0, b_writedata, b_byteenable);
    if (a_wr_p0 && (a_address == b_address)) b_word_p0 = byte_merge(b_word_p0, a_writedata, a_byteenable);
    // On a same-address double write, port B's lanes land first and A overrides
    if (same_wr_p0) a_base_p0 = byte_merge(a_base_p0, b_writedata, b_byteenable);
  end

  always_ff @(posedge clk) begin
    if (clr_vld_p0) begin
      mem[clr_addr] <= '0;
    end else begin
      if (b_wr_p0 && !same_wr_p0) mem[b_address] <= byte_merge(mem[b_address], b_writedata, b_byteenable);
      if (a_wr_p0) mem[a_address] <= byte_merge(a_base_p0, a_writedata, a_byteenable);
    end
  end

  // Stage p1: registered read data, handshake outputs and init sequencer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= RST;
      clr_addr        <= '0;
      a_waitrequest   <= 1'b1;
      b_waitrequest   <= 1'b1;
      init_done       <= 1'b0;
      a_readdatavalid <= 1'b0;
      b_readdatavalid <= 1'b0;
      a_readdata      <= '0;
      b_readdata      <= '0;
    end else begin
      a_readdatavalid <= a_vld_p0;
      b_readdatavalid <= b_vld_p0;
      if (a_vld_p0) a_readdata <= a_word_p0;
      if (b_vld_p0) b_readdata <= b_word_p0;
      case (state)
        RST: begin
          clr_addr <= '0;
          if (CLEAR_ON_RESET) begin
            state <= CLEAR;
          end else begin
            state         <= READY;
            a_waitrequest <= 1'b0;
            b_waitrequest <= 1'b0;
            init_done     <= 1'b1;
          end
        end
        CLEAR: begin
          // Hold the counter at the last address instead of wrapping to zero
          if (clr_addr == {ADDR_W{1'b1}}) begin
            state         <= READY;
            a_waitrequest <= 1'b0;
            b_waitrequest <= 1'b0;
            init_done     <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        READY: state <= READY;
        default: begin
          state         <= RST;
          a_waitrequest <= 1'b1;
          b_waitrequest <= 1'b1;
          init_done     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_currctrl_dpram.sv
// Scoreboard bench for currctrl_dpram: a default instance with zero-fill and
// a small 16-bit / 16-word instance without fill.
module tb_currctrl_dpram;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int BW  = DW / 8;
  localparam int SDW = 16;
  localparam int SAW = 4;
  localparam int SBW = SDW / 8;

  typedef struct packed {
    logic aw; logic ar; logic [AW-1:0] aa; logic [DW-1:0] ad; logic [BW-1:0] ab;
    logic bw; logic br; logic [AW-1:0] ba; logic [DW-1:0] bd; logic [BW-1:0] bb;
    logic fz;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, freeze;
  logic [AW-1:0] a_address, b_address;
  logic a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
  logic [BW-1:0] a_byteenable, b_byteenable;
  logic [DW-1:0] a_writedata, b_writedata, a_readdata, b_readdata;
  logic a_readdatavalid, b_readdatavalid, a_waitrequest, b_waitrequest, init_done;

  logic s_reset_n, s_freeze;
  logic [SAW-1:0] s_a_address, s_b_address;
  logic s_a_chipselect, s_a_read, s_a_write, s_b_chipselect, s_b_read, s_b_write;
  logic [SBW-1:0] s_a_byteenable, s_b_byteenable;
  logic [SDW-1:0] s_a_writedata, s_b_writedata, s_a_readdata, s_b_readdata;
  logic s_a_readdatavalid, s_b_readdatavalid, s_a_waitrequest, s_b_waitrequest, s_init_done;

  currctrl_dpram dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .freeze(freeze),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid), .a_waitrequest(a_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid), .b_waitrequest(b_waitrequest),
    .init_done(init_done)
  );

  currctrl_dpram #(.DATA_W(SDW), .ADDR_W(SAW), .CLEAR_ON_RESET(1'b0)) dut_s (
    .clk(clk), .reset_n(s_reset_n),
    .a_address(s_a_address), .a_chipselect(s_a_chipselect), .a_read(s_a_read), .a_write(s_a_write),
    .a_byteenable(s_a_byteenable), .a_writedata(s_a_writedata),
    .b_address(s_b_address), .b_chipselect(s_b_chipselect), .b_read(s_b_read), .b_write(s_b_write),
    .b_byteenable(s_b_byteenable), .b_writedata(s_b_writedata),
    .freeze(s_freeze),
    .a_readdata(s_a_readdata), .a_readdatavalid(s_a_readdatavalid), .a_waitrequest(s_a_waitrequest),
    .b_readdata(s_b_readdata), .b_readdatavalid(s_b_readdatavalid), .b_waitrequest(s_b_waitrequest),
    .init_done(s_init_done)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0]  model [256];
  logic [SDW-1:0] model_s [16];
  logic [DW-1:0]  exp_a[$], exp_b[$];

  function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic op_t wa(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    op_t o = '0;
    o.aw = 1'b1; o.aa = AW'(a); o.ad = d; o.ab = be;
    return o;
  endfunction
  function automatic op_t wb(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    op_t o = '0;
    o.bw = 1'b1; o.ba = AW'(a); o.bd = d; o.bb = be;
    return o;
  endfunction
  function automatic op_t ra(input int a);
    op_t o = '0;
    o.ar = 1'b1; o.aa = AW'(a);
    return o;
  endfunction
  function automatic op_t rb(input int a);
    op_t o = '0;
    o.br = 1'b1; o.ba = AW'(a);
    return o;
  endfunction
  function automatic op_t fz();
    op_t o = '0;
    o.fz = 1'b1;
    return o;
  endfunction

  task automatic idle();
    a_chipselect = 0; a_read = 0; a_write = 0; a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_chipselect = 0; b_read = 0; b_write = 0; b_address = '0; b_byteenable = '0; b_writedata = '0;
    freeze = 0;
  endtask

  task automatic s_idle();
    s_a_chipselect = 0; s_a_read = 0; s_a_write = 0; s_a_address = '0; s_a_byteenable = '0; s_a_writedata = '0;
    s_b_chipselect = 0; s_b_read = 0; s_b_write = 0; s_b_address = '0; s_b_byteenable = '0; s_b_writedata = '0;
    s_freeze = 0;
  endtask

  // Drive one cycle of stimulus and record what the memory must do with it.
  task automatic apply(input op_t o);
    logic aw, bw;
    logic [DW-1:0] w;
    a_chipselect = o.aw | o.ar; a_write = o.aw; a_read = o.ar; a_address = o.aa; a_writedata = o.ad; a_byteenable = o.ab;
    b_chipselect = o.bw | o.br; b_write = o.bw; b_read = o.br; b_address = o.ba; b_writedata = o.bd; b_byteenable = o.bb;
    freeze = o.fz;
    aw = o.aw && !o.fz;
    bw = o.bw && !o.fz;
    if (o.ar && !o.aw) begin
      w = model[o.aa];
      if (bw && o.ba == o.aa) w = bmerge(w, o.bd, o.bb);
      exp_a.push_back(w);
    end
    if (o.br && !o.bw) begin
      w = model[o.ba];
      if (aw && o.aa == o.ba) w = bmerge(w, o.ad, o.ab);
      exp_b.push_back(w);
    end
    if (bw) model[o.ba] = bmerge(model[o.ba], o.bd, o.bb);
    if (aw) model[o.aa] = bmerge(model[o.aa], o.ad, o.ab);
  endtask

  // Steps the fill with a read held on port B; reports wait cycles and any early activity.
  task automatic count_fill(input int limit, output int n, output bit early);
    n = 0;
    early = 1'b0;
    b_chipselect = 1; b_read = 1; b_address = '0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (a_readdatavalid || b_readdatavalid) early = 1'b1;
      if (!a_waitrequest && !b_waitrequest) break;
      if (init_done) early = 1'b1;
      n++;
    end
    idle();
  endtask

  task automatic test_reset();
    reset_n = 0; s_reset_n = 0; idle(); s_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_waitrequest, b_waitrequest, init_done} !== 3'b110) begin
      errors++; $display("FAIL reset_ctrl: wait_a/wait_b/init=%b expected 110", {a_waitrequest, b_waitrequest, init_done});
    end
    checks++;
    if ({a_readdatavalid, b_readdatavalid} !== 2'b00 || a_readdata !== '0 || b_readdata !== '0) begin
      errors++; $display("FAIL reset_rd: valid=%b a=%h b=%h expected 00 0 0", {a_readdatavalid, b_readdatavalid}, a_readdata, b_readdata);
    end
    checks++;
    if ({s_a_waitrequest, s_b_waitrequest, s_init_done, s_a_readdatavalid, s_b_readdatavalid} !== 5'b11000 || s_a_readdata !== '0) begin
      errors++; $display("FAIL reset_small: ctrl=%b data=%h expected 11000 0",
        {s_a_waitrequest, s_b_waitrequest, s_init_done, s_a_readdatavalid, s_b_readdatavalid}, s_a_readdata);
    end
  endtask

  task automatic test_fill();
    int n; bit early; logic ev; logic [DW-1:0] ed; op_t t [3];
    reset_n = 1;
    count_fill(400, n, early);
    checks++; if (n != 256) begin errors++; $display("FAIL fill_len: %0d wait cycles expected 256", n); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL fill_done: init_done=%b expected 1", init_done); end
    checks++; if (early) begin errors++; $display("FAIL fill_early: activity=1 before ready, expected 0"); end
    for (int i = 0; i < 256; i++) model[i] = '0;
    t = '{op_t'(ra(0) | rb(128)), ra(255), '0};
    foreach (t[i]) begin
      apply(t[i]); @(posedge clk); #1;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL fill_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL fill_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
  endtask

  task automatic test_byteenable();
    logic ev; logic [DW-1:0] ed; op_t t [5]; logic [DW-1:0] ga [5], gb [5];
    t = '{wa(5, 32'hAABBCCDD, 4'b0101), rb(5), wa(5, 32'hFFFFFFFF, 4'b0000), ra(5), '0};
    foreach (t[i]) begin
      apply(t[i]); @(posedge clk); #1;
      ga[i] = a_readdata; gb[i] = b_readdata;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL be_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL be_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
    checks++; if (gb[1] !== 32'h00BB00DD) begin errors++; $display("FAIL be_lanes: got %h expected 00bb00dd", gb[1]); end
    checks++; if (ga[3] !== 32'h00BB00DD) begin errors++; $display("FAIL be_zero_noop: got %h expected 00bb00dd", ga[3]); end
    checks++; if (ga[4] !== 32'h00BB00DD || gb[4] !== 32'h00BB00DD) begin
      errors++; $display("FAIL rd_hold: a=%h b=%h expected 00bb00dd", ga[4], gb[4]);
    end
  endtask

  task automatic test_dual_write();
    logic ev; logic [DW-1:0] ed; op_t t [3]; logic [DW-1:0] ga [3];
    t = '{op_t'(wa(9, 32'h11111111, 4'b0011) | wb(9, 32'h22222222, 4'b1111)), ra(9), '0};
    foreach (t[i]) begin
      apply(t[i]); @(posedge clk); #1;
      ga[i] = a_readdata;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL dual_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL dual_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
    checks++; if (ga[1] !== 32'h22221111) begin errors++; $display("FAIL dual_a_wins: got %h expected 22221111", ga[1]); end
  endtask

  task automatic test_collision();
    logic ev; logic [DW-1:0] ed; op_t t [6]; logic [DW-1:0] gb [6];
    t = '{wa(3, 32'h12345678, 4'hF), op_t'(wa(3, 32'hFFFFFFFF, 4'b1000) | rb(3)),
          wa(3, 32'h12345678, 4'hF), op_t'(wa(3, 32'hFFFFFFFF, 4'b1000) | rb(3) | fz()), rb(3), '0};
    foreach (t[i]) begin
      apply(t[i]); @(posedge clk); #1;
      gb[i] = b_readdata;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL coll_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL coll_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
    checks++; if (gb[1] !== 32'hFF345678) begin errors++; $display("FAIL coll_forward: got %h expected ff345678", gb[1]); end
    checks++; if (gb[3] !== 32'h12345678) begin errors++; $display("FAIL coll_freeze_rd: got %h expected 12345678", gb[3]); end
    checks++; if (gb[4] !== 32'h12345678) begin errors++; $display("FAIL freeze_mem: got %h expected 12345678", gb[4]); end
  endtask

  task automatic test_diff_addr();
    logic ev; logic [DW-1:0] ed; op_t t [6]; logic [DW-1:0] ga [6], gb [6];
    t = '{wa(7, 32'hCAFEF00D, 4'hF), wb(8, 32'h0BADBEEF, 4'hF), op_t'(ra(7) | wb(8, 32'hDEADBEEF, 4'hF)),
          op_t'(wa(8, 32'h12121212, 4'hF) | ra(8)), rb(8), '0};
    foreach (t[i]) begin
      apply(t[i]); @(posedge clk); #1;
      ga[i] = a_readdata; gb[i] = b_readdata;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL diff_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL diff_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
    checks++; if (ga[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL diff_addr: got %h expected cafef00d", ga[2]); end
    checks++; if (gb[4] !== 32'h12121212) begin errors++; $display("FAIL rw_is_write: got %h expected 12121212", gb[4]); end
  endtask

  task automatic test_back_to_back();
    logic ev; logic [DW-1:0] ed; op_t o;
    for (int i = 0; i < 300; i++) begin
      o = '0;
      o.aa = AW'($urandom_range(0, 7)); o.ba = AW'($urandom_range(0, 7));
      o.ad = $urandom; o.bd = $urandom;
      o.ab = BW'($urandom_range(0, 15)); o.bb = BW'($urandom_range(0, 15));
      o.ar = 1'($urandom_range(0, 1)); o.aw = 1'($urandom_range(0, 1));
      o.br = 1'($urandom_range(0, 1)); o.bw = 1'($urandom_range(0, 1));
      o.fz = ($urandom_range(0, 9) == 0);
      if (i == 299) o = '0;
      apply(o); @(posedge clk); #1;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL b2b_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL b2b_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
  endtask

  task automatic test_abort_refill();
    int n; bit early; logic ev; logic [DW-1:0] ed; op_t t [6];
    t = '{op_t'(wa(0, 32'h5A5A5A5A, 4'hF) | wb(128, 32'hA5A5A5A5, 4'hF)), wa(255, 32'h0F0F0F0F, 4'hF),
          '0, op_t'(ra(0) | rb(128)), ra(255), '0};
    for (int i = 0; i < 2; i++) apply(t[i]);
    idle();
    a_chipselect = 1; a_write = 1; a_address = 8'd0; a_writedata = 32'h5A5A5A5A; a_byteenable = 4'hF;
    b_chipselect = 1; b_write = 1; b_address = 8'd128; b_writedata = 32'hA5A5A5A5; b_byteenable = 4'hF;
    @(posedge clk); #1;
    idle(); a_chipselect = 1; a_write = 1; a_address = 8'd255; a_writedata = 32'h0F0F0F0F; a_byteenable = 4'hF;
    @(posedge clk); #1;
    idle(); reset_n = 0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    count_fill(101, n, early);
    checks++; if (n != 101) begin errors++; $display("FAIL abort_part: %0d wait cycles expected 101", n); end
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({a_waitrequest, init_done} !== 2'b10) begin errors++; $display("FAIL abort_rst: wait/init=%b expected 10", {a_waitrequest, init_done}); end
    reset_n = 1;
    count_fill(400, n, early);
    checks++; if (n != 256) begin errors++; $display("FAIL refill_len: %0d wait cycles expected 256", n); end
    checks++; if (early) begin errors++; $display("FAIL refill_early: activity=1 before ready, expected 0"); end
    for (int i = 0; i < 256; i++) model[i] = '0;
    for (int i = 3; i < 6; i++) begin
      apply(t[i]); @(posedge clk); #1;
      checks += 2;
      ev = 0; ed = '0; if (exp_a.size() != 0) begin ev = 1; ed = exp_a.pop_front(); end
      if (a_readdatavalid !== ev || (ev && a_readdata !== ed)) begin
        errors++; $display("FAIL refill_rd_a step %0d: valid=%b data=%h expected valid=%b data=%h", i, a_readdatavalid, a_readdata, ev, ed);
      end
      ev = 0; ed = '0; if (exp_b.size() != 0) begin ev = 1; ed = exp_b.pop_front(); end
      if (b_readdatavalid !== ev || (ev && b_readdata !== ed)) begin
        errors++; $display("FAIL refill_rd_b step %0d: valid=%b data=%h expected valid=%b data=%h", i, b_readdatavalid, b_readdata, ev, ed);
      end
    end
  endtask

  task automatic test_small();
    logic [SDW-1:0] ea, eb;
    s_reset_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({s_init_done, s_a_waitrequest, s_b_waitrequest} !== 3'b100) begin
      errors++; $display("FAIL small_ready: init/wait_a/wait_b=%b expected 100", {s_init_done, s_a_waitrequest, s_b_waitrequest});
    end
    for (int i = 0; i < 8; i++) begin
      s_a_chipselect = 1; s_a_write = 1; s_a_address = SAW'(i); s_a_byteenable = 2'b11; s_a_writedata = 16'($urandom);
      s_b_chipselect = 1; s_b_write = 1; s_b_address = SAW'(i + 8); s_b_byteenable = 2'b11; s_b_writedata = 16'($urandom);
      model_s[i] = s_a_writedata; model_s[i + 8] = s_b_writedata;
      @(posedge clk); #1;
    end
    s_idle(); s_reset_n = 0;
    repeat (2) @(posedge clk);
    #1; s_reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      s_a_chipselect = 1; s_a_read = 1; s_a_address = SAW'(i);
      s_b_chipselect = 1; s_b_read = 1; s_b_address = SAW'(15 - i);
      ea = model_s[i]; eb = model_s[15 - i];
      @(posedge clk); #1;
      checks += 2;
      if (s_a_readdatavalid !== 1'b1 || s_a_readdata !== ea) begin
        errors++; $display("FAIL small_b2b_a step %0d: valid=%b data=%h expected valid=1 data=%h", i, s_a_readdatavalid, s_a_readdata, ea);
      end
      if (s_b_readdatavalid !== 1'b1 || s_b_readdata !== eb) begin
        errors++; $display("FAIL small_b2b_b step %0d: valid=%b data=%h expected valid=1 data=%h", i, s_b_readdatavalid, s_b_readdata, eb);
      end
    end
    s_idle();
    @(posedge clk); #1;
    checks++;
    if ({s_a_readdatavalid, s_b_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL small_idle: valid=%b expected 00", {s_a_readdatavalid, s_b_readdatavalid});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_byteenable();
    test_dual_write();
    test_collision();
    test_diff_addr();
    test_back_to_back();
    test_abort_refill();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/currctrl_dpram.md
CURRCTRL_DPRAM -- requirements
Module: currctrl_dpram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the memory after reset, 0 = no fill.
REQ-004 SHALL derive BE_W = DATA_W/8 internally.
REQ-005 clk  input  1  single clock for both ports and all state.
REQ-006 reset_n  input  1  synchronous reset, active-low.
REQ-007 a_address, b_address  input  ADDR_W  word address, port A / B.
REQ-008 a_chipselect, b_chipselect  input  1  port select.
REQ-009 a_read, b_read  input  1  read request.
REQ-010 a_write, b_write  input  1  write request.
REQ-011 a_byteenable, b_byteenable  input  BE_W  per-byte write lane enables.
REQ-012 a_writedata, b_writedata  input  DATA_W  write data.
REQ-013 freeze  input  1  high suppresses all writes.
REQ-014 a_readdata, b_readdata  output  DATA_W  registered read data.
REQ-015 a_readdatavalid, b_readdatavalid  output  1  one-cycle strobe marking valid readdata.
REQ-016 a_waitrequest, b_waitrequest  output  1  high = port stalled; no transfer is accepted.
REQ-017 init_done  output  1  high once the memory is ready.

Function
REQ-018 SHALL implement FSM states RST, CLEAR, READY; a transfer is accepted only in READY, when chipselect & (read|write) & !waitrequest.
REQ-019 RST exit: if CLEAR_ON_RESET=1, SHALL enter CLEAR on the first cycle with reset_n high; otherwise SHALL enter READY.
REQ-020 CLEAR SHALL write all-zero to one word per cycle, at addresses 0 to DEPTH-1 ascending, then enter READY; the fill lasts exactly DEPTH cycles.
REQ-021 In RST and CLEAR, both waitrequests SHALL be 1 and init_done SHALL be 0.
REQ-022 In READY, both waitrequests SHALL be 0 and init_done SHALL be 1.
REQ-023 An accepted write SHALL update only the bytes whose byteenable bit is 1; byteenable=0 SHALL be a no-op.
REQ-024 While freeze=1, accepted writes SHALL be discarded; reads SHALL be unaffected; freeze SHALL be ignored during CLEAR.
REQ-025 An accepted read SHALL assert readdatavalid on the next cycle, with readdata = the word at that address; latency is exactly 1.
REQ-026 readdata SHALL hold its last value when readdatavalid=0.
REQ-027 Same-port read and write asserted together SHALL be treated as a write only; no readdatavalid is produced.
REQ-028 Both ports writing the same address in one cycle: port A SHALL win on overlapping lanes; port B SHALL write its non-overlapping lanes.
REQ-029 One port reading the address the other port writes in the same cycle SHALL return new data, byte-merged with the old word per the writer's byteenable; freeze=1 SHALL return old data.
REQ-030 A port reading an address while the other port writes a different address SHALL return the stored word unaffected.
REQ-031 All address arithmetic SHALL be ADDR_W-bit; the clear counter SHALL terminate at DEPTH-1 without wrapping back into CLEAR.

Reset
REQ-032 While reset_n=0 at a clk edge: FSM SHALL go to RST; readdata=0, readdatavalid=0, waitrequest=1, init_done=0 on both ports.
REQ-033 reset_n=0 during CLEAR SHALL abort the fill; the next release SHALL restart the fill at address 0.
REQ-034 Memory contents SHALL NOT be cleared by reset itself; with CLEAR_ON_RESET=0 they persist across reset.

Verification
REQ-035 Default parameters, release reset -> waitrequest=1 for exactly 256 cycles; init_done rises on cycle 257; reads of addresses 0, 128 and 255 return 0.
REQ-036 A writes 0xAABBCCDD to addr 5 with byteenable=0b0101 over zero memory -> a read of addr 5 via B, 1 cycle later, returns 0x00BB00DD.
REQ-037 Same cycle: A writes 0x11111111, be=0b0011, and B writes 0x22222222, be=0b1111, both to addr 9 -> a later read of addr 9 returns 0x22221111.
REQ-038 addr 3 holds 0x12345678; A writes 0xFFFFFFFF, be=0b1000, to addr 3 while B reads addr 3 -> next cycle b_readdatavalid=1 and b_readdata=0xFF345678; repeat with freeze=1 -> 0x12345678, and memory is unchanged.
REQ-039 Assert reset_n=0 at fill address 100, release -> the fill restarts at 0, takes 256 cycles, and no read is accepted before init_done=1.
REQ-040 DATA_W=16, ADDR_W=4, CLEAR_ON_RESET=0 -> READY on the first cycle after release; back-to-back reads on both ports each give valid data 1 cycle later every cycle.
